// File: rtl/rf_scrub_ctrl_if.sv
// rtl/rf_scrub_ctrl_if.sv - pipeline/decoder/writeback signal bundle for the RF scrubber
interface rf_scrub_ctrl_if #(
    parameter int WORD_WIDTH   = 32,
    parameter int RF_ADD_WIDTH = 5
);
    logic                    s_enable_i;
    logic                    s_rf_free_i;
    logic                    s_wb_free_i;
    logic                    s_pipe_we_i;
    logic [RF_ADD_WIDTH-1:0] s_pipe_wadd_i;
    logic                    s_rdata_ce_i;
    logic                    s_rdata_uce_i;
    logic [WORD_WIDTH-1:0]   s_rdata_cor_i;
    logic                    s_rreq_o;
    logic [RF_ADD_WIDTH-1:0] s_radd_o;
    logic                    s_we_o;
    logic [RF_ADD_WIDTH-1:0] s_wadd_o;
    logic [WORD_WIDTH-1:0]   s_wdata_o;
    logic                    s_ce_o;
    logic                    s_uce_o;
    logic [RF_ADD_WIDTH-1:0] s_err_add_o;
    logic                    s_busy_o;

    // scrubber side
    modport slave (
        input  s_enable_i, s_rf_free_i, s_wb_free_i, s_pipe_we_i, s_pipe_wadd_i,
               s_rdata_ce_i, s_rdata_uce_i, s_rdata_cor_i,
        output s_rreq_o, s_radd_o, s_we_o, s_wadd_o, s_wdata_o,
               s_ce_o, s_uce_o, s_err_add_o, s_busy_o
    );

    // pipeline / decoder / CSR side
    modport master (
        output s_enable_i, s_rf_free_i, s_wb_free_i, s_pipe_we_i, s_pipe_wadd_i,
               s_rdata_ce_i, s_rdata_uce_i, s_rdata_cor_i,
        input  s_rreq_o, s_radd_o, s_we_o, s_wadd_o, s_wdata_o,
               s_ce_o, s_uce_o, s_err_add_o, s_busy_o
    );
endinterface

// File: rtl/rf_scrub_ctrl.sv
// rtl/rf_scrub_ctrl.sv - background register-file ECC scrubber (read, check, correct)
module rf_scrub_ctrl #(
    parameter int INTERVAL     = 64,
    parameter int WORD_WIDTH   = 32,
    parameter int RF_ADD_WIDTH = 5
) (
    input  logic          s_clk_i,
    input  logic          s_rst_i,
    rf_scrub_ctrl_if.slave bus
);
    localparam int CNT_W = (INTERVAL < 1) ? 1 : $clog2(INTERVAL + 1);
    // Reload gives INTERVAL full idle cycles after a finished operation.
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(INTERVAL);
    localparam logic [CNT_W-1:0] CNT_RESET  = CNT_W'(INTERVAL - 1);
    localparam logic [RF_ADD_WIDTH-1:0] ADD_FIRST = RF_ADD_WIDTH'(1);

    typedef enum logic [1:0] {ACM_IDLE, ACM_CHECK, ACM_CORRECT} state_t;

    state_t                  state, state_n;
    logic [RF_ADD_WIDTH-1:0] ptr, ptr_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [WORD_WIDTH-1:0]   data_q, data_n;
    logic [RF_ADD_WIDTH-1:0] err_q, err_n;
    logic                    hazard;
    logic                    done;

    // A pipeline write to the word under scrub makes our copy stale; x0 never matches since ptr>=1.
    assign hazard = bus.s_pipe_we_i && (bus.s_pipe_wadd_i == ptr);

    // State, pointer, interval counter, corrected-data latch and error address registers
    always_ff @(posedge s_clk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            state  <= ACM_IDLE;
            ptr    <= ADD_FIRST;
            cnt    <= CNT_RESET;
            data_q <= '0;
            err_q  <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            err_q  <= err_n;
        end
    end

    // Next-state and output decode; 'done' closes an operation (advance pointer, reload interval)
    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        cnt_n         = cnt;
        data_n        = data_q;
        err_n         = err_q;
        done          = 1'b0;
        bus.s_rreq_o  = 1'b0;
        bus.s_we_o    = 1'b0;
        bus.s_wadd_o  = '0;
        bus.s_wdata_o = '0;
        bus.s_ce_o    = 1'b0;
        bus.s_uce_o   = 1'b0;

        case (state)
            ACM_IDLE: begin
                if (bus.s_enable_i) begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CNT_W'(1);
                    end else if (bus.s_rf_free_i) begin
                        bus.s_rreq_o = 1'b1;
                        state_n      = ACM_CHECK;
                    end
                end
            end
            ACM_CHECK: begin
                if (hazard) begin
                    done = 1'b1;
                end else if (bus.s_rdata_uce_i) begin
                    bus.s_uce_o = 1'b1;
                    err_n       = ptr;
                    done        = 1'b1;
                end else if (bus.s_rdata_ce_i) begin
                    data_n  = bus.s_rdata_cor_i;
                    state_n = ACM_CORRECT;
                end else begin
                    done = 1'b1;
                end
            end
            ACM_CORRECT: begin
                if (hazard) begin
                    done = 1'b1;
                end else if (bus.s_wb_free_i) begin
                    bus.s_we_o    = 1'b1;
                    bus.s_wadd_o  = ptr;
                    bus.s_wdata_o = data_q;
                    bus.s_ce_o    = 1'b1;
                    err_n         = ptr;
                    done          = 1'b1;
                end
            end
            default: state_n = ACM_IDLE;
        endcase

        if (done) begin
            state_n = ACM_IDLE;
            cnt_n   = CNT_RELOAD;
            ptr_n   = (ptr == '1) ? ADD_FIRST : ptr + ADD_FIRST;
        end
    end

    // The reported address follows ptr in the pulse cycle, then holds the registered value.
    assign bus.s_err_add_o = (bus.s_ce_o || bus.s_uce_o) ? ptr : err_q;
    assign bus.s_radd_o    = ptr;
    assign bus.s_busy_o    = (state != ACM_IDLE);
endmodule

// File: tb/tb_rf_scrub_ctrl.sv
// tb/tb_rf_scrub_ctrl.sv - scoreboard bench for rf_scrub_ctrl
module tb_rf_scrub_ctrl;
    localparam int INTERVAL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   nxt;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  add;
        logic [31:0] data;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t uce_q[$];

    always #5 clk = ~clk;

    rf_scrub_ctrl_if #(.WORD_WIDTH(32), .RF_ADD_WIDTH(5)) bus ();

    rf_scrub_ctrl #(.INTERVAL(INTERVAL), .WORD_WIDTH(32), .RF_ADD_WIDTH(5)) dut (
        .s_clk_i (clk),
        .s_rst_i (rst),
        .bus     (bus)
    );

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read, write or uce pulse
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (bus.s_rreq_o) begin
                check("rreq_rf_free", {31'd0, bus.s_rf_free_i}, 32'd1);
                if (rd_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rreq_unexpected at cycle %0d: got rreq=1 radd=%0d, expected rreq=0", cyc, bus.s_radd_o);
                end else begin
                    e = rd_q.pop_front();
                    check("rreq_cycle", cyc, e.cyc);
                    check("radd", {27'd0, bus.s_radd_o}, {27'd0, e.add});
                end
            end
            if (bus.s_we_o) begin
                check("we_wb_free", {31'd0, bus.s_wb_free_i}, 32'd1);
                if (wr_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL we_unexpected at cycle %0d: got we=1 wadd=%0d, expected we=0", cyc, bus.s_wadd_o);
                end else begin
                    e = wr_q.pop_front();
                    check("we_cycle", cyc, e.cyc);
                    check("wadd", {27'd0, bus.s_wadd_o}, {27'd0, e.add});
                    check("wdata", bus.s_wdata_o, e.data);
                    check("ce_pulse", {31'd0, bus.s_ce_o}, 32'd1);
                    check("err_add_ce", {27'd0, bus.s_err_add_o}, {27'd0, e.add});
                end
            end else begin
                check("wadd_idle_zero", {27'd0, bus.s_wadd_o}, 32'd0);
                check("wdata_idle_zero", bus.s_wdata_o, 32'd0);
                check("ce_without_we", {31'd0, bus.s_ce_o}, 32'd0);
            end
            if (bus.s_uce_o) begin
                if (uce_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL uce_unexpected at cycle %0d: got uce=1 err_add=%0d, expected uce=0", cyc, bus.s_err_add_o);
                end else begin
                    e = uce_q.pop_front();
                    check("uce_cycle", cyc, e.cyc);
                    check("err_add_uce", {27'd0, bus.s_err_add_o}, {27'd0, e.add});
                    check("uce_no_we", {31'd0, bus.s_we_o}, 32'd0);
                end
            end
        end
    end

    // kind: 0 clean, 1 correctable, 2 correctable+uncorrectable
    task automatic scrub(input logic [4:0] a, input int kind, input logic [31:0] cor,
                         input int wb_hold, input int rf_hold, input logic pw,
                         input logic [4:0] pw_add, input logic drop_en);
        ev_t e;
        int  w;
        if (rf_hold > 0) begin
            bus.s_rf_free_i = 1'b0;
            while (cyc < nxt + rf_hold) step();
            bus.s_rf_free_i = 1'b1;
            nxt += rf_hold;
        end
        e.cyc = nxt; e.add = a; e.data = '0;
        rd_q.push_back(e);
        while (cyc < nxt) step();
        step();
        bus.s_rdata_ce_i  = (kind != 0);
        bus.s_rdata_uce_i = (kind == 2);
        bus.s_rdata_cor_i = cor;
        if (drop_en) bus.s_enable_i = 1'b0;
        if (kind == 2) begin
            e.cyc = nxt + 1; e.add = a; e.data = '0;
            uce_q.push_back(e);
        end
        step();
        bus.s_rdata_ce_i  = 1'b0;
        bus.s_rdata_uce_i = 1'b0;
        bus.s_rdata_cor_i = '0;
        if (kind != 1) begin
            nxt += 6;
        end else begin
            w = nxt + 2 + wb_hold;
            if (pw) begin
                bus.s_pipe_we_i   = 1'b1;
                bus.s_pipe_wadd_i = pw_add;
            end
            if (!(pw && pw_add == a)) begin
                e.cyc = w; e.add = a; e.data = cor;
                wr_q.push_back(e);
            end
            if (wb_hold > 0) begin
                bus.s_wb_free_i = 1'b0;
                repeat (wb_hold) begin
                    check("busy_while_wb_blocked", {31'd0, bus.s_busy_o}, 32'd1);
                    step();
                end
                bus.s_wb_free_i = 1'b1;
            end
            step();
            bus.s_pipe_we_i   = 1'b0;
            bus.s_pipe_wadd_i = '0;
            nxt = w + 5;
        end
    endtask

    initial begin
        bus.s_enable_i    = 1'b1;
        bus.s_rf_free_i   = 1'b1;
        bus.s_wb_free_i   = 1'b1;
        bus.s_pipe_we_i   = 1'b0;
        bus.s_pipe_wadd_i = '0;
        bus.s_rdata_ce_i  = 1'b0;
        bus.s_rdata_uce_i = 1'b0;
        bus.s_rdata_cor_i = '0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_rreq", {31'd0, bus.s_rreq_o}, 32'd0);
        check("reset_we", {31'd0, bus.s_we_o}, 32'd0);
        check("reset_busy", {31'd0, bus.s_busy_o}, 32'd0);
        check("reset_err_add", {27'd0, bus.s_err_add_o}, 32'd0);
        check("reset_radd", {27'd0, bus.s_radd_o}, 32'd1);
        check("reset_uce", {31'd0, bus.s_uce_o}, 32'd0);

        nxt = 3;
        for (int a = 1; a <= 4; a++) scrub(5'(a), 0, 32'h0, 0, 0, 1'b0, 5'd0, 1'b0);
        scrub(5'd5,  1, 32'hDEADBEEF, 0, 0, 1'b0, 5'd0,  1'b0);
        scrub(5'd6,  0, 32'h0,        0, 0, 1'b0, 5'd0,  1'b0);
        scrub(5'd7,  1, 32'h12345678, 3, 0, 1'b0, 5'd0,  1'b0);
        scrub(5'd8,  0, 32'h0,        0, 0, 1'b0, 5'd0,  1'b0);
        scrub(5'd9,  2, 32'hCAFEF00D, 0, 0, 1'b0, 5'd0,  1'b0);
        check("err_add_held_after_uce", {27'd0, bus.s_err_add_o}, 32'd9);
        scrub(5'd10, 0, 32'h0,        0, 0, 1'b0, 5'd0,  1'b0);
        scrub(5'd11, 0, 32'h0,        0, 0, 1'b0, 5'd0,  1'b0);
        scrub(5'd12, 1, 32'h55AA55AA, 0, 0, 1'b1, 5'd12, 1'b0);
        scrub(5'd13, 1, 32'hA5A5A5A5, 0, 0, 1'b1, 5'd0,  1'b0);
        scrub(5'd14, 0, 32'h0,        0, 2, 1'b0, 5'd0,  1'b0);
        for (int a = 15; a <= 31; a++) scrub(5'(a), 0, 32'h0, 0, 0, 1'b0, 5'd0, 1'b0);
        scrub(5'd1,  0, 32'h0,        0, 0, 1'b0, 5'd0,  1'b0);
        scrub(5'd2,  1, 32'h0BADF00D, 0, 0, 1'b0, 5'd0,  1'b1);

        repeat (15) step();
        check("disabled_busy", {31'd0, bus.s_busy_o}, 32'd0);
        check("disabled_err_add_held", {27'd0, bus.s_err_add_o}, 32'd2);
        bus.s_enable_i = 1'b1;
        nxt = cyc + 4;

        scrub(5'd3, 1, 32'h0F0F0F0F, 0, 0, 1'b0, 5'd0, 1'b0);
        bus.s_wb_free_i = 1'b0;
        rd_q.push_back('{cyc: nxt, add: 5'd4, data: 32'h0});
        while (cyc < nxt) step();
        step();
        bus.s_rdata_ce_i  = 1'b1;
        bus.s_rdata_cor_i = 32'h77777777;
        step();
        bus.s_rdata_ce_i  = 1'b0;
        bus.s_rdata_cor_i = '0;
        step();
        check("busy_before_reset", {31'd0, bus.s_busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("midreset_busy", {31'd0, bus.s_busy_o}, 32'd0);
        check("midreset_radd", {27'd0, bus.s_radd_o}, 32'd1);
        check("midreset_err_add", {27'd0, bus.s_err_add_o}, 32'd0);
        check("midreset_we", {31'd0, bus.s_we_o}, 32'd0);
        bus.s_wb_free_i = 1'b1;
        step();
        rst = 1'b0;
        rd_q.push_back('{cyc: 3, add: 5'd1, data: 32'h0});
        while (cyc < 4) step();
        step();

        check("rd_queue_drained", rd_q.size(), 32'd0);
        check("wr_queue_drained", wr_q.size(), 32'd0);
        check("uce_queue_drained", uce_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1);
    end
endmodule
